mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 61 ++++++
 rtl/mem_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// Bus bundle for the memory controller: RAM port,
// instruction fetch channel and SLB issue/return channel.
interface mem_ctrl_if;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_done;
   logic [31:0] fetch_inst;
   logic        slb_load;
   logic        slb_store;
   logic [5:0]  slb_mem_order;
   logic [31:0] slb_mem_vj;
   logic [31:0] slb_mem_vk;
   logic [31:0] slb_mem_A;
   logic        memctrl_data_ready;
   logic [31:0] memctrl_data_ret;

   modport master (
      input  mem_din,
      input  io_buffer_full,
      input  fetch_req,
      input  fetch_addr,
      input  slb_load,
      input  slb_store,
      input  slb_mem_order,
      input  slb_mem_vj,
      input  slb_mem_vk,
      input  slb_mem_A,
      output mem_dout,
      output mem_a,
      output mem_wr,
      output fetch_done,
      output fetch_inst,
      output memctrl_data_ready,
      output memctrl_data_ret
   );

   modport slave (
      output mem_din,
      output io_buffer_full,
      output fetch_req,
      output fetch_addr,
      output slb_load,
      output slb_store,
      output slb_mem_order,
      output slb_mem_vj,
      output slb_mem_vk,
      output slb_mem_A,
      input  mem_dout,
      input  mem_a,
      input  mem_wr,
      input  fetch_done,
      input  fetch_inst,
      input  memctrl_data_ready,
      input  memctrl_data_ret
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction
// fetch and SLB loads/stores onto a single 8-bit RAM port.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear,
   mem_ctrl_if.master  bus
);

   localparam logic [31:0] IO_BASE = 32'h0003_0000;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      LOAD,
      STORE
   } state_t;

   typedef struct packed {
      logic        st;
      logic [1:0]  w;
      logic [31:0] a;
      logic [31:0] d;
      logic        q;
   } mreq_t;

   function automatic logic [1:0] wlast(
      input logic [5:0] o
   );
      unique case (1'b1)
         (o == 6'd11) || (o == 6'd14) || (o == 6'd16):
            wlast = 2'd0;
         (o == 6'd12) || (o == 6'd15) || (o == 6'd17):
            wlast = 2'd1;
         default:
            wlast = 2'd3;
      endcase
   endfunction

   state_t      st;
   logic [1:0]  cnt;
   logic        ph;
   mreq_t       cur;
   mreq_t       pend;
   logic        p_v;
   logic [31:0] rbuf;
   logic [31:0] a_q;
   logic [7:0]  dout_q;
   logic        wr_q;
   logic        fd_q;
   logic [31:0] inst_q;
   logic        dr_q;
   logic [31:0] ret_q;

   mreq_t       req;
   mreq_t       lnch;
   logic        req_v;
   logic        pend_ok;
   logic        l_go;
   logic        leave_f;
   logic        go_op;
   logic        go_f;
   logic [2:0]  c1;
   logic [2:0]  c2;
   logic        rd_last;
   logic [31:0] rd_a;
   logic [31:0] rnext;
   logic        stall;
   logic        wr_go;
   logic [7:0]  nbyte;

   // A pending load dies on clear; a pending store must still run.
   always_comb begin
      req.st  = bus.slb_store;
      req.w   = wlast(bus.slb_mem_order);
      req.a   = bus.slb_mem_vj + bus.slb_mem_A;
      req.d   = bus.slb_mem_vk;
      req.q   = 1'b0;
      req_v   = (bus.slb_load | bus.slb_store)
              & rdy & ~clear;
      pend_ok = p_v & (pend.st | ~clear);
      l_go    = pend_ok | (~p_v & req_v);
      lnch    = pend_ok ? pend : req;
      lnch.q  = pend_ok & (pend.q | clear);
   end

   // Skip fetch accept while fetch_done is up: fetch_addr is stale.
   always_comb begin
      leave_f = (st == FETCH)
              & (clear | ~bus.fetch_req | rd_last);
      go_op   = rdy & l_go
              & ((st == IDLE) | leave_f);
      go_f    = rdy & (st == IDLE) & ~p_v & ~req_v
              & bus.fetch_req & ~fd_q & ~clear;
   end

   always_comb begin
      c1      = {1'b0, cnt} + 3'd1;
      c2      = c1 + 3'd1;
      rd_last = ph & (cnt == cur.w);
      rd_a    = 32'd0;
      if (!ph && c1 <= {1'b0, cur.w})
         rd_a = cur.a + 32'(c1);
      else if (ph && c2 <= {1'b0, cur.w})
         rd_a = cur.a + 32'(c2);
      rnext   = rbuf
              | (32'(bus.mem_din) << {cnt, 3'b000});
      stall   = (a_q >= IO_BASE) & bus.io_buffer_full;
      wr_go   = wr_q & cur.st & rdy & ~stall;
      nbyte   = 8'(cur.d >> {cnt + 2'd1, 3'b000});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st     <= IDLE;
         cnt    <= '0;
         ph     <= 1'b0;
         cur    <= '0;
         pend   <= '0;
         p_v    <= 1'b0;
         rbuf   <= '0;
         a_q    <= '0;
         dout_q <= '0;
         wr_q   <= 1'b0;
         fd_q   <= 1'b0;
         inst_q <= '0;
         dr_q   <= 1'b0;
         ret_q  <= '0;
      end else begin
         fd_q <= 1'b0;
         dr_q <= 1'b0;
         if (!rdy) begin
            // Re-request the first byte not yet captured.
            if (st == FETCH || st == LOAD) begin
               ph  <= 1'b0;
               a_q <= cur.a + 32'(cnt);
            end
         end else begin
            unique case (st)
               IDLE: begin
                  if (p_v && !pend_ok)
                     p_v <= 1'b0;
               end
               FETCH: begin
                  if (leave_f) begin
                     st  <= IDLE;
                     a_q <= '0;
                     p_v <= 1'b0;
                     if (rd_last && bus.fetch_req
                         && !clear) begin
                        fd_q   <= 1'b1;
                        inst_q <= rnext;
                     end
                  end else begin
                     ph  <= 1'b1;
                     a_q <= rd_a;
                     if (ph) begin
                        rbuf <= rnext;
                        cnt  <= cnt + 2'd1;
                     end
                     if (req_v && !p_v) begin
                        pend <= req;
                        p_v  <= 1'b1;
                     end
                  end
               end
               LOAD: begin
                  if (clear) begin
                     st  <= IDLE;
                     a_q <= '0;
                  end else if (rd_last) begin
                     st    <= IDLE;
                     a_q   <= '0;
                     dr_q  <= 1'b1;
                     ret_q <= rnext;
                  end else begin
                     ph  <= 1'b1;
                     a_q <= rd_a;
                     if (ph) begin
                        rbuf <= rnext;
                        cnt  <= cnt + 2'd1;
                     end
                  end
               end
               STORE: begin
                  if (clear)
                     cur.q <= 1'b1;
                  if (wr_go) begin
                     if (cnt == cur.w) begin
                        st     <= IDLE;
                        wr_q   <= 1'b0;
                        a_q    <= '0;
                        dout_q <= '0;
                        dr_q   <= ~cur.q & ~clear;
                        ret_q  <= '0;
                     end else begin
                        cnt    <= cnt + 2'd1;
                        a_q    <= a_q + 32'd1;
                        dout_q <= nbyte;
                     end
                  end
               end
            endcase

            if (go_op) begin
               st     <= lnch.st ? STORE : LOAD;
               cur    <= lnch;
               cnt    <= '0;
               ph     <= 1'b0;
               rbuf   <= '0;
               p_v    <= 1'b0;
               a_q    <= lnch.a;
               wr_q   <= lnch.st;
               dout_q <= lnch.st ? lnch.d[7:0] : 8'd0;
            end else if (go_f) begin
               st     <= FETCH;
               cur.st <= 1'b0;
               cur.w  <= 2'd3;
               cur.a  <= bus.fetch_addr;
               cur.d  <= '0;
               cur.q  <= 1'b0;
               cnt    <= '0;
               ph     <= 1'b0;
               rbuf   <= '0;
               a_q    <= bus.fetch_addr;
               wr_q   <= 1'b0;
               dout_q <= '0;
            end
         end
      end
   end

   assign bus.mem_a              = a_q;
   assign bus.mem_dout           = dout_q;
   assign bus.mem_wr             = wr_go;
   assign bus.fetch_done         = fd_q & ~clear;
   assign bus.fetch_inst         = inst_q;
   assign bus.memctrl_data_ready = dr_q & ~clear;
   assign bus.memctrl_data_ret   = ret_q;

endmodule
